uio_bus_arbiter: RTL and testbench



---
 rtl/uio_bus_arbiter.sv | 159 +++++++++++++++
 tb/tb_uio_bus_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uio_bus_arbiter.sv
// Round-robin owner arbitration for the shared 8-bit uio pad group.
// Tenures are bounded and always followed by a bus-release turnaround.
module uio_bus_arbiter #(
   parameter int         NUM_REQ     = 4,
   parameter int         MAX_HOLD    = 16,
   parameter int         TURN_CYCLES = 1,
   parameter logic [7:0] OE_MASK     = 8'hFF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ena,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [NUM_REQ-1:0]   dir,
   input  logic [8*NUM_REQ-1:0] wr_data,
   output logic [NUM_REQ-1:0]   gnt,
   input  logic [7:0]           uio_in,
   output logic [7:0]           uio_out,
   output logic [7:0]           uio_oe,
   output logic [7:0]           rd_data,
   output logic                 rd_valid,
   output logic                 busy
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int HW = $clog2(MAX_HOLD + 2);
   localparam int TW = $clog2(TURN_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      TURN
   } state_t;

   state_t               state_q, state_d;
   logic [NUM_REQ-1:0]   gnt_q, gnt_d;
   logic                 dir_q, dir_d;
   logic [PW-1:0]        ptr_q, ptr_d;
   logic [HW-1:0]        hold_q, hold_d;
   logic [TW-1:0]        turn_q, turn_d;
   logic [7:0]           oe_q, oe_d;
   logic [7:0]           rdat_q, rdat_d;
   logic                 rval_q, rval_d;

   logic [PW-1:0]        cand;
   logic [PW-1:0]        win;
   logic                 found;
   logic                 req_cur;
   logic                 hold_hit;
   logic [7:0]           wr_sel;

   // Search starts one past the last owner, so the last owner ranks lowest.
   always_comb begin
      cand  = '0;
      win   = '0;
      found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = PW'((int'(ptr_q) + k) % NUM_REQ);
         if (!found && req[cand]) begin
            win   = cand;
            found = 1'b1;
         end
      end
   end

   assign req_cur  = |(req & gnt_q);
   assign hold_hit = (MAX_HOLD != 0) &&
                     (hold_q == HW'(MAX_HOLD - 1));

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      dir_d   = dir_q;
      ptr_d   = ptr_q;
      hold_d  = hold_q;
      turn_d  = turn_q;
      oe_d    = oe_q;
      rdat_d  = rdat_q;
      rval_d  = 1'b0;
      unique case (1'b1)
         (state_q == IDLE): begin
            gnt_d = '0;
            oe_d  = '0;
            if (ena && found) begin
               state_d    = GRANT;
               gnt_d[win] = 1'b1;
               dir_d      = dir[win];
               ptr_d      = win;
               hold_d     = '0;
               oe_d       = dir[win] ? OE_MASK : 8'h00;
            end
         end
         (state_q == GRANT): begin
            hold_d = hold_q + 1'b1;
            if (!dir_q && req_cur) begin
               rdat_d = uio_in;
               rval_d = 1'b1;
            end
            if (!req_cur || hold_hit) begin
               state_d = TURN;
               gnt_d   = '0;
               oe_d    = '0;
               hold_d  = '0;
               turn_d  = '0;
            end
         end
         (state_q == TURN): begin
            if (turn_q == TW'(TURN_CYCLES - 1))
               state_d = IDLE;
            else
               turn_d = turn_q + 1'b1;
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
            oe_d    = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         dir_q   <= 1'b0;
         ptr_q   <= PW'(NUM_REQ - 1);
         hold_q  <= '0;
         turn_q  <= '0;
         oe_q    <= '0;
         rdat_q  <= '0;
         rval_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         dir_q   <= dir_d;
         ptr_q   <= ptr_d;
         hold_q  <= hold_d;
         turn_q  <= turn_d;
         oe_q    <= oe_d;
         rdat_q  <= rdat_d;
         rval_q  <= rval_d;
      end
   end

   // Grant is one-hot, so an OR-reduce acts as the write mux.
   always_comb begin
      wr_sel = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (gnt_q[i])
            wr_sel = wr_sel | wr_data[8*i +: 8];
   end

   assign uio_out  = (|oe_q) ? wr_sel : 8'h00;
   assign uio_oe   = oe_q;
   assign gnt      = gnt_q;
   assign rd_data  = rdat_q;
   assign rd_valid = rval_q;
   assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Directed bench for uio_bus_arbiter with default parameters.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_uio_bus_arbiter;

   logic        clk;
   logic        rst_n;
   logic        ena;
   logic [3:0]  req;
   logic [3:0]  dir;
   logic [31:0] wr_data;
   logic [3:0]  gnt;
   logic [7:0]  uio_in;
   logic [7:0]  uio_out;
   logic [7:0]  uio_oe;
   logic [7:0]  rd_data;
   logic        rd_valid;
   logic        busy;

   int n_chk  = 0;
   int n_fail = 0;

   logic [7:0] wb [4] = '{8'h11, 8'h22, 8'hA5, 8'h44};
   int         ord [5] = '{0, 1, 2, 3, 0};

   uio_bus_arbiter dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ena      (ena),
      .req      (req),
      .dir      (dir),
      .wr_data  (wr_data),
      .gnt      (gnt),
      .uio_in   (uio_in),
      .uio_out  (uio_out),
      .uio_oe   (uio_oe),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      int len;
      int gap;
      logic [3:0] exp_g;

      rst_n   = 1'b0;
      ena     = 1'b1;
      req     = 4'b1111;
      dir     = 4'b0000;
      wr_data = 32'h44A52211;
      uio_in  = 8'h00;

      // reset hold with all requests pending
      repeat (3) tick();
      chk("rst_gnt", gnt, 4'b0000);
      chk("rst_oe", uio_oe, 8'h00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_rval", rd_valid, 1'b0);
      chk("rst_rdat", rd_data, 8'h00);
      chk("rst_out", uio_out, 8'h00);
      rst_n = 1'b1;
      tick();
      chk("first_gnt", gnt, 4'b0001);
      chk("first_busy", busy, 1'b1);
      req = 4'b0000;
      tick();
      chk("first_turn_gnt", gnt, 4'b0000);
      chk("first_turn_busy", busy, 1'b1);
      tick();
      chk("first_idle_busy", busy, 1'b0);

      // single write tenure of 5 cycles
      req = 4'b0100;
      dir = 4'b0100;
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("wr_gnt", gnt, 4'b0100);
         chk("wr_oe", uio_oe, 8'hFF);
         chk("wr_out", uio_out, 8'hA5);
         if (i == 4) req = 4'b0000;
         tick();
      end
      chk("wr_turn_oe", uio_oe, 8'h00);
      chk("wr_turn_gnt", gnt, 4'b0000);
      chk("wr_turn_out", uio_out, 8'h00);
      chk("wr_turn_busy", busy, 1'b1);
      tick();
      chk("wr_idle_busy", busy, 1'b0);

      // read capture
      req    = 4'b0010;
      dir    = 4'b0000;
      uio_in = 8'h10;
      tick();
      chk("rd_gnt", gnt, 4'b0010);
      chk("rd_oe0", uio_oe, 8'h00);
      chk("rd_val0", rd_valid, 1'b0);
      uio_in = 8'h10;
      tick();
      chk("rd_val1", rd_valid, 1'b1);
      chk("rd_dat1", rd_data, 8'h10);
      chk("rd_oe1", uio_oe, 8'h00);
      uio_in = 8'h11;
      tick();
      chk("rd_val2", rd_valid, 1'b1);
      chk("rd_dat2", rd_data, 8'h11);
      uio_in = 8'h12;
      tick();
      chk("rd_val3", rd_valid, 1'b1);
      chk("rd_dat3", rd_data, 8'h12);
      chk("rd_oe3", uio_oe, 8'h00);
      req    = 4'b0000;
      uio_in = 8'h13;
      tick();
      chk("rd_turn_val", rd_valid, 1'b0);
      chk("rd_turn_dat", rd_data, 8'h12);
      tick();

      // round robin with all four requesting writes
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      req   = 4'b1111;
      dir   = 4'b1111;
      tick();
      for (int t = 0; t < 5; t++) begin
         exp_g = 4'(1 << ord[t]);
         chk("rr_gnt", gnt, exp_g);
         len = 0;
         while (gnt == exp_g && len < 40) begin
            chk("rr_oe", uio_oe, 8'hFF);
            chk("rr_out", uio_out, wb[ord[t]]);
            len++;
            tick();
         end
         chk("rr_len", len, 16);
         if (t < 4) begin
            gap = 0;
            while (gnt == 4'b0000 && gap < 10) begin
               chk("rr_gap_oe", uio_oe, 8'h00);
               gap++;
               tick();
            end
            chk("rr_gap", gap, 2);
         end
      end
      req = 4'b0000;
      tick();
      tick();

      // preemption of a writer followed by a reader
      rst_n = 1'b0;
      req   = 4'b1001;
      dir   = 4'b0001;
      tick();
      rst_n = 1'b1;
      tick();
      chk("pre_gnt0", gnt, 4'b0001);
      len = 0;
      while (gnt == 4'b0001 && len < 40) begin
         chk("pre_oe0", uio_oe, 8'hFF);
         chk("pre_out0", uio_out, 8'h11);
         len++;
         tick();
      end
      chk("pre_len0", len, 16);
      gap = 0;
      while (gnt == 4'b0000 && gap < 10) begin
         chk("pre_gap_oe", uio_oe, 8'h00);
         gap++;
         tick();
      end
      chk("pre_gap", gap, 2);
      chk("pre_gnt3", gnt, 4'b1000);
      len = 0;
      while (gnt == 4'b1000 && len < 40) begin
         chk("pre_oe3", uio_oe, 8'h00);
         chk("pre_out3", uio_out, 8'h00);
         len++;
         tick();
      end
      chk("pre_len3", len, 16);
      req = 4'b0000;
      tick();
      tick();

      // reset during a write tenure, then ena gating
      req = 4'b0100;
      dir = 4'b0100;
      tick();
      chk("mr_gnt", gnt, 4'b0100);
      chk("mr_oe", uio_oe, 8'hFF);
      tick();
      rst_n = 1'b0;
      tick();
      chk("mr_rst_gnt", gnt, 4'b0000);
      chk("mr_rst_oe", uio_oe, 8'h00);
      chk("mr_rst_out", uio_out, 8'h00);
      chk("mr_rst_busy", busy, 1'b0);
      rst_n = 1'b1;
      ena   = 1'b0;
      req   = 4'b0010;
      dir   = 4'b0000;
      tick();
      chk("ena0_gnt_a", gnt, 4'b0000);
      tick();
      chk("ena0_gnt_b", gnt, 4'b0000);
      chk("ena0_busy", busy, 1'b0);
      ena = 1'b1;
      tick();
      chk("ena1_gnt", gnt, 4'b0010);
      chk("ena1_oe", uio_oe, 8'h00);
      req = 4'b0000;
      repeat (3) tick();
      chk("end_busy", busy, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
